render_texto: RTL

//  Text-overlay renderer between the VGA sync generator and the 8x16 character ROM.

---
 rtl/render_texto_pkg.sv | 21 ++
 rtl/render_texto_if.sv | 41 ++++
 rtl/render_texto_blink_gen.sv | 33 +++
 rtl/render_texto.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/render_texto_pkg.sv
// rtl/render_texto_pkg.sv - glyph geometry, char codes and RGB332 colours for the text overlay
package render_texto_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    typedef enum logic [2:0] {
        ESPACIO = 3'd0,
        J       = 3'd1,
        V       = 3'd2,
        M       = 3'd3,
        B       = 3'd4,
        S       = 3'd5,
        L       = 3'd6
    } char_code_t;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_NAVY  = 8'h03;

endpackage

// File: rtl/render_texto_if.sv
// rtl/render_texto_if.sv - video timing, text-buffer write and glyph ROM bundle (cursor_addr under RENDER_CURSOR_EN)
interface render_texto_if;

    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_i;
    logic       vsync_i;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [2:0] wr_char;
`ifdef RENDER_CURSOR_EN
    logic [4:0] cursor_addr;
`endif
    logic [2:0] direccion;
    logic [3:0] rom;
    logic [7:0] rom_data;
    logic [7:0] rgb;
    logic       hsync_o;
    logic       vsync_o;

    modport slave (
`ifdef RENDER_CURSOR_EN
        input  cursor_addr,
`endif
        input  pixel_tick, pixel_x, pixel_y, video_on, hsync_i, vsync_i,
        input  wr_en, wr_addr, wr_char, rom_data,
        output direccion, rom, rgb, hsync_o, vsync_o
    );

    modport master (
`ifdef RENDER_CURSOR_EN
        output cursor_addr,
`endif
        output pixel_tick, pixel_x, pixel_y, video_on, hsync_i, vsync_i,
        output wr_en, wr_addr, wr_char, rom_data,
        input  direccion, rom, rgb, hsync_o, vsync_o
    );

endinterface

// File: rtl/render_texto_blink_gen.sv
// rtl/render_texto_blink_gen.sv - frame counter toggling the cursor blink state every BLINK_FR frames
module blink_gen #(
    parameter int BLINK_FR = 30
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_frame_start,
    output logic o_blink_on
);

    localparam int CW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_blink;

    // count frame starts; wrap after BLINK_FR of them and flip the blink phase
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (i_frame_start) begin
            if (r_cnt == CW'(BLINK_FR - 1)) begin
                r_cnt   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_blink_on = r_blink;

endmodule

// File: rtl/render_texto.sv
// rtl/render_texto.sv - 3-stage text overlay renderer; RENDER_CURSOR_EN adds a blinking cursor
module render_texto
    import render_texto_pkg::*;
#(
    parameter int         TEXT_X0 = 256,
    parameter int         TEXT_Y0 = 224,
    parameter int         COLS    = 16,
    parameter int         ROWS    = 2,
    parameter logic [7:0] FG      = RGB_WHITE,
    parameter logic [7:0] BG      = RGB_NAVY
`ifdef RENDER_CURSOR_EN
    , parameter int       BLINK_FR = 30
`endif
) (
    input logic           i_clk,
    input logic           i_reset,
    render_texto_if.slave bus
);

    localparam logic [9:0] X0     = 10'(TEXT_X0);
    localparam logic [9:0] Y0     = 10'(TEXT_Y0);
    localparam logic [9:0] WIN_W  = 10'(COLS * CHAR_W);
    localparam logic [9:0] WIN_H  = 10'(ROWS * CHAR_H);
    localparam logic [9:0] COLS_V = 10'(COLS);
    localparam logic [5:0] NCELL  = 6'(COLS * ROWS);

    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic [4:0] w_cell;
    logic       w_in_win;
    logic       w_pix;
    logic       w_pix_out;

    logic [2:0] r_buf [0:31];

    logic [4:0] r_cell_s1;
    logic [3:0] r_line_s1;
    logic [2:0] r_bit_s1;
    logic       r_win_s1, r_von_s1, r_hs_s1, r_vs_s1;

    logic [2:0] r_dir;
    logic [3:0] r_rom;
    logic [2:0] r_bit_s2;
    logic       r_win_s2, r_von_s2, r_hs_s2, r_vs_s2;

    logic [7:0] r_rgb;
    logic       r_hs_o, r_vs_o;

    // window-relative coordinates; pixels left/above the window wrap to large values and fall out
    assign w_dx     = bus.pixel_x - X0;
    assign w_dy     = bus.pixel_y - Y0;
    assign w_in_win = bus.video_on && (w_dx < WIN_W) && (w_dy < WIN_H);
    assign w_cell   = 5'(((w_dy >> 4) * COLS_V) + (w_dx >> 3));

    // text buffer: written from the clk domain regardless of pixel_tick, out-of-range cells dropped
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 3'd0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < NCELL)) begin
            r_buf[bus.wr_addr] <= bus.wr_char;
        end
    end

    // S1: locate the pixel inside the text grid
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cell_s1 <= '0;
            r_line_s1 <= '0;
            r_bit_s1  <= '0;
            r_win_s1  <= 1'b0;
            r_von_s1  <= 1'b0;
            r_hs_s1   <= 1'b1;
            r_vs_s1   <= 1'b1;
        end else if (bus.pixel_tick) begin
            r_cell_s1 <= w_cell;
            r_line_s1 <= w_dy[3:0];
            r_bit_s1  <= w_dx[2:0];
            r_win_s1  <= w_in_win;
            r_von_s1  <= bus.video_on;
            r_hs_s1   <= bus.hsync_i;
            r_vs_s1   <= bus.vsync_i;
        end
    end

    // S2: fetch the char code and present the ROM address
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_dir    <= '0;
            r_rom    <= '0;
            r_bit_s2 <= '0;
            r_win_s2 <= 1'b0;
            r_von_s2 <= 1'b0;
            r_hs_s2  <= 1'b1;
            r_vs_s2  <= 1'b1;
        end else if (bus.pixel_tick) begin
            r_dir    <= r_buf[r_cell_s1];
            r_rom    <= r_line_s1;
            r_bit_s2 <= r_bit_s1;
            r_win_s2 <= r_win_s1;
            r_von_s2 <= r_von_s1;
            r_hs_s2  <= r_hs_s1;
            r_vs_s2  <= r_vs_s1;
        end
    end

    // MSB of the glyph row is the leftmost pixel, so column b maps to bit 7-b
    assign w_pix = bus.rom_data[~r_bit_s2];

`ifdef RENDER_CURSOR_EN
    logic [4:0] r_cell_s2;
    logic       w_frame_start;
    logic       w_blink_on;

    assign w_frame_start = bus.pixel_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);

    blink_gen #(.BLINK_FR(BLINK_FR)) u_blink (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_frame_start (w_frame_start),
        .o_blink_on    (w_blink_on)
    );

    // carry the cell index alongside S2 so the cursor compare lines up with rom_data
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cell_s2 <= '0;
        end else if (bus.pixel_tick) begin
            r_cell_s2 <= r_cell_s1;
        end
    end

    assign w_pix_out = w_pix ^ (w_blink_on && (r_cell_s2 == bus.cursor_addr));
`else
    assign w_pix_out = w_pix;
`endif

    // S3: colour the pixel and realign the syncs with it
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rgb  <= RGB_BLACK;
            r_hs_o <= 1'b1;
            r_vs_o <= 1'b1;
        end else if (bus.pixel_tick) begin
            r_rgb  <= (!r_von_s2 || !r_win_s2) ? RGB_BLACK : (w_pix_out ? FG : BG);
            r_hs_o <= r_hs_s2;
            r_vs_o <= r_vs_s2;
        end
    end

    assign bus.direccion = r_dir;
    assign bus.rom       = r_rom;
    assign bus.rgb       = r_rgb;
    assign bus.hsync_o   = r_hs_o;
    assign bus.vsync_o   = r_vs_o;

endmodule
